input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Conditions one asynchronous, noisy digital input (button or switch) for use in the synchronous design.
- Three stages, in order:
  - 2-flop synchronizer for metastability.
  - Counter-based debouncer.
  - Edge detector that emits single-cycle rising and falling pulses.
- Sits between top-level input pins and the control logic.

Parameters:
- COUNTER_WIDTH, 3, width of the debounce counter; must satisfy 2^COUNTER_WIDTH > WAIT_TIME.
- WAIT_TIME, 3, count value at which a pending change is accepted into conditioned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- noisysignal  input  1  raw asynchronous input.
- conditioned  output  1  synchronized, debounced level (registered).
- positiveedge  output  1  one-cycle pulse when conditioned goes 0->1 (registered).
- negativeedge  output  1  one-cycle pulse when conditioned goes 1->0 (registered).
- glitchcount  output  8  only when INPUTCONDITIONER_GLITCH_COUNT_EN is defined; see Optional Feature.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: when reset=1 at a clk rising edge, the following all clear to 0: sync0, sync1, counter, conditioned, positiveedge, negativeedge (and glitchcount). A pending transition is abandoned. Reset has priority over all other updates.
- Synchronizer: each edge, sync0 <= noisysignal and sync1 <= sync0. Only sync1 feeds the debouncer.
- Debouncer, evaluated each edge when not in reset:
  - sync1 == conditioned: counter <= 0; no change to conditioned.
  - sync1 != conditioned and counter == WAIT_TIME: conditioned <= sync1; counter <= 0.
  - Otherwise: counter <= counter + 1.
- Latency: a change at noisysignal that is stable before clock edge E1 changes conditioned at edge E1+WAIT_TIME+2.
  - With defaults, that is the 6th rising edge after the change.
  - conditioned holds its old value at edges E1..E1+WAIT_TIME+1.
- Glitch rejection:
  - If sync1 returns to conditioned before counter reaches WAIT_TIME, the counter resets to 0 and conditioned does not change.
  - A later mismatch restarts counting from 0; no accumulation across glitches.
- Edge pulses:
  - At the same edge that conditioned updates 0->1, positiveedge <= 1. At every other edge, positiveedge <= 0.
  - negativeedge behaves the same for a 1->0 update.
  - Both pulses last exactly one cycle and are never high simultaneously.
  - Neither pulses on reset.
- Back-to-back transitions: a new opposite transition needs its own full WAIT_TIME+1 mismatch cycles, so successive edge pulses are at least WAIT_TIME+1 cycles apart.
- Counter never exceeds WAIT_TIME; no wrap-around.

Optional Feature:
- Macro: INPUTCONDITIONER_GLITCH_COUNT_EN.
- When defined:
  - Adds 8-bit output glitchcount, reset to 0.
  - Increments by 1 at each edge where counter != 0 and sync1 == conditioned (a pending change aborted as a glitch).
  - Saturates at 255.
- When undefined: the port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
- Synchronize/debounce rise: reset, hold noisysignal=0, clk period 20, release reset. Set noisysignal=1 at t=120. conditioned=0 sampled at each of the next 6 rising edges (130..230). conditioned=1 at t=231.
- Edge pulse: in the same run, positiveedge=1 only in the cycle after edge 230; 0 before and after. negativeedge stays 0.
- Fall: from settled 1, set noisysignal=0 -> conditioned=0 after 6 edges. negativeedge is high for exactly one cycle; positiveedge stays 0.
- Glitch: from settled 0, pulse noisysignal=1 for 2 clock cycles, then 0 -> conditioned stays 0 for the next 20 cycles; no edge pulses; glitchcount=1 if the feature is enabled.
- Reset mid-operation: set noisysignal=1, assert reset at the 4th edge for one cycle, deassert. Outputs are 0 during reset. conditioned=1 only 6 edges after reset release (noisysignal still 1); single positiveedge pulse.
- Chatter: toggle noisysignal every 3 cycles for 30 cycles, then hold 1 -> conditioned stays 0 during chatter, rises 6 edges after the last toggle, one positiveedge pulse total.

Source files
------------

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Conditions one asynchronous, noisy digital input (button or switch) for use
// in the synchronous design. Three stages, in order:
//   1. 2-flop synchronizer (sync0 -> sync1) against metastability.
//   2. Counter-based debouncer: a mismatch between sync1 and the conditioned
//      level must persist for WAIT_TIME+1 consecutive edges before it is
//      accepted. Any return to the current level aborts the pending change.
//   3. Edge detector: single-cycle registered pulses on accepted 0->1 / 1->0
//      updates of the conditioned level.
//
// Parameters:
//   COUNTER_WIDTH  width of the debounce counter (2**COUNTER_WIDTH > WAIT_TIME)
//   WAIT_TIME      counter value at which a pending change is accepted
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   noisysignal   in   raw asynchronous input
//   conditioned   out  synchronized, debounced level (registered)
//   positiveedge  out  one-cycle pulse when conditioned goes 0->1 (registered)
//   negativeedge  out  one-cycle pulse when conditioned goes 1->0 (registered)
//   glitchcount   out  [7:0] saturating count of aborted pending changes;
//                      present only when INPUTCONDITIONER_GLITCH_COUNT_EN is
//                      defined
//
// Optional feature macro: INPUTCONDITIONER_GLITCH_COUNT_EN
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int COUNTER_WIDTH = 3,
  parameter int WAIT_TIME     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noisysignal,
  output logic       conditioned,
  output logic       positiveedge,
  output logic       negativeedge
`ifdef INPUTCONDITIONER_GLITCH_COUNT_EN
  ,
  output logic [7:0] glitchcount
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);

  // Synchronizer flops; only sync1_q is allowed to feed any logic.
  logic sync0_q;
  logic sync1_q;

  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic                     cond_q,    cond_d;
  logic                     pos_q,     pos_d;
  logic                     neg_q,     neg_d;

  // ---------------------------------------------------------------------------
  // Debounce / edge next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    counter_d = counter_q;
    cond_d    = cond_q;
    pos_d     = 1'b0;
    neg_d     = 1'b0;

    if (sync1_q == cond_q) begin
      // Input agrees with the accepted level: drop any pending change.
      counter_d = '0;
    end else if (counter_q == WAIT_CNT) begin
      // Mismatch has lasted WAIT_TIME+1 edges: accept it and flag the edge.
      cond_d    = sync1_q;
      counter_d = '0;
      pos_d     = sync1_q;
      neg_d     = ~sync1_q;
    end else begin
      // Counter stops at WAIT_CNT because the branch above fires there.
      counter_d = counter_q + COUNTER_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that sync1_q
    // takes the old sync0_q, not the value written earlier in this block.
    if (reset) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      counter_q <= '0;
      cond_q    <= 1'b0;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      sync0_q   <= noisysignal;
      sync1_q   <= sync0_q;
      counter_q <= counter_d;
      cond_q    <= cond_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;

`ifdef INPUTCONDITIONER_GLITCH_COUNT_EN
  // ---------------------------------------------------------------------------
  // Glitch counter: a pending change (counter non-zero) that is abandoned
  // because the input returned to the accepted level.
  // ---------------------------------------------------------------------------
  logic       glitch_abort;
  logic [7:0] glitch_q, glitch_d;

  assign glitch_abort = (sync1_q == cond_q) && (counter_q != '0);

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_abort && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitchcount = glitch_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Scoreboard bench for input_conditioner. A reference model, clocked on the
// same rising edge, describes the block as "the input seen two edges late must
// disagree with the accepted level for WAIT_TIME+1 edges in a row before it is
// accepted" and pushes the expected outputs for every edge into a queue. A
// separate monitor samples the DUT 1 time unit after each rising edge, pops
// the expectation and compares. Directed phases follow the intended usage
// scenarios; a randomized phase and a glitch-saturation phase follow.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int CW = 3;
  localparam int WT = 3;

  logic clk         = 1'b0;
  logic reset       = 1'b1;
  logic noisysignal = 1'b0;
  logic conditioned;
  logic positiveedge;
  logic negativeedge;
  logic [7:0] glitch_obs;

`ifdef INPUTCONDITIONER_GLITCH_COUNT_EN
  logic [7:0] glitchcount;
  assign glitch_obs = glitchcount;
`else
  assign glitch_obs = 8'd0;
`endif

  input_conditioner #(
    .COUNTER_WIDTH(CW),
    .WAIT_TIME    (WT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .noisysignal (noisysignal),
    .conditioned (conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge)
`ifdef INPUTCONDITIONER_GLITCH_COUNT_EN
    ,
    .glitchcount (glitchcount)
`endif
  );

  // Period 20, rising edges at 10, 30, 50, ...
  always #10 clk = ~clk;

  typedef struct packed {
    logic       cond;
    logic       pos;
    logic       neg;
    logic [7:0] glitch;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pos_seen = 0;
  int   neg_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit hist[$] = '{1'b0, 1'b0};  // input samples from the two previous edges
  int run     = 0;              // consecutive edges the late input disagreed
  bit m_cond  = 1'b0;
  int m_glitch = 0;

  always @(posedge clk) begin
    obs_t e;
    bit   seen;
    e = '0;
    if (reset) begin
      hist     = '{1'b0, 1'b0};
      run      = 0;
      m_cond   = 1'b0;
      m_glitch = 0;
    end else begin
      seen = hist.pop_front();
      hist.push_back(noisysignal);
      if (seen == m_cond) begin
        if (run > 0 && m_glitch < 255) m_glitch++;
        run = 0;
      end else begin
        run++;
        if (run == WT + 1) begin
          m_cond = seen;
          e.pos  = seen;
          e.neg  = !seen;
          run    = 0;
        end
      end
    end
    e.cond = m_cond;
`ifdef INPUTCONDITIONER_GLITCH_COUNT_EN
    e.glitch = 8'(m_glitch);
`endif
    exp_q.push_back(e);
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    obs_t a;
    obs_t e;
    #1;
    a.cond   = conditioned;
    a.pos    = positiveedge;
    a.neg    = negativeedge;
    a.glitch = glitch_obs;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_cycle{cond,pos,neg,glitch}", 32'(a), 32'(e));
    end
    if (positiveedge === 1'b1) pos_seen++;
    if (negativeedge === 1'b1) neg_seen++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int p0, n0;
    logic [7:0] g0;

    // Reset for edges 10 and 30, release at t=40.
    tick(2);
    check("reset_cond", 32'(conditioned), 32'd0);
    check("reset_pos",  32'(positiveedge), 32'd0);
    check("reset_neg",  32'(negativeedge), 32'd0);
    check("reset_glitch", 32'(glitch_obs), 32'd0);
    reset = 1'b0;

    // Rise: noisysignal=1 at t=120.
    tick(4);
    p0 = pos_seen; n0 = neg_seen;
    noisysignal = 1'b1;
    tick(5);  // t=220, after edges 130..210
    check("rise_held_low", 32'(conditioned), 32'd0);
    tick(1);  // t=240, after edge 230
    check("rise_cond", 32'(conditioned), 32'd1);
    check("rise_pulse_now", 32'(positiveedge), 32'd1);
    tick(10);
    check("rise_pos_count", 32'(pos_seen - p0), 32'd1);
    check("rise_neg_count", 32'(neg_seen - n0), 32'd0);

    // Fall from settled 1.
    p0 = pos_seen; n0 = neg_seen;
    noisysignal = 1'b0;
    tick(12);
    check("fall_cond", 32'(conditioned), 32'd0);
    check("fall_neg_count", 32'(neg_seen - n0), 32'd1);
    check("fall_pos_count", 32'(pos_seen - p0), 32'd0);

    // Glitch: two-cycle pulse from settled 0.
    p0 = pos_seen; n0 = neg_seen; g0 = glitch_obs;
    noisysignal = 1'b1;
    tick(2);
    noisysignal = 1'b0;
    tick(20);
    check("glitch_cond", 32'(conditioned), 32'd0);
    check("glitch_pulses", 32'((pos_seen - p0) + (neg_seen - n0)), 32'd0);
`ifdef INPUTCONDITIONER_GLITCH_COUNT_EN
    check("glitch_count_delta", 32'(glitch_obs - g0), 32'd1);
`endif

    // Reset mid-operation.
    noisysignal = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midrst_cond", 32'(conditioned), 32'd0);
    check("midrst_pos",  32'(positiveedge), 32'd0);
    check("midrst_neg",  32'(negativeedge), 32'd0);
    reset = 1'b0;
    p0 = pos_seen;
    tick(5);
    check("midrst_held_low", 32'(conditioned), 32'd0);
    tick(1);
    check("midrst_cond_after", 32'(conditioned), 32'd1);
    tick(6);
    check("midrst_pos_count", 32'(pos_seen - p0), 32'd1);

    // Return to 0, then chatter every 3 cycles for 30 cycles, then hold 1.
    noisysignal = 1'b0;
    tick(12);
    p0 = pos_seen; n0 = neg_seen;
    for (int i = 0; i < 10; i++) begin
      noisysignal = ~noisysignal;
      tick(3);
      if (conditioned !== 1'b0) check("chatter_cond", 32'(conditioned), 32'd0);
    end
    noisysignal = 1'b1;
    tick(5);
    check("chatter_held_low", 32'(conditioned), 32'd0);
    tick(1);
    check("chatter_cond_after", 32'(conditioned), 32'd1);
    tick(6);
    check("chatter_pos_count", 32'(pos_seen - p0), 32'd1);
    check("chatter_neg_count", 32'(neg_seen - n0), 32'd0);

    // Randomized segments with occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 2));
        reset = 1'b0;
      end
      noisysignal = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 8));
    end

    // Glitch saturation: many aborted two-cycle pulses from settled 0.
    noisysignal = 1'b0;
    tick(12);
    for (int i = 0; i < 270; i++) begin
      noisysignal = 1'b1;
      tick(2);
      noisysignal = 1'b0;
      tick(2);
    end
    tick(4);
    check("sat_cond", 32'(conditioned), 32'd0);
`ifdef INPUTCONDITIONER_GLITCH_COUNT_EN
    check("sat_glitch", 32'(glitch_obs), 32'd255);
`endif

    tick(2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
